// File: rtl/mem_stage_hs.sv
// MEM stage: ALU pass-through or one dmem load/store per instruction; ALU/misaligned results 1 cycle, memory ops 1 + ack latency.
// Backpressure: ex_ready drops for the whole memory wait; memory side holds req until ack or TIMEOUT cycles elapse.
module mem_stage_hs #(
    parameter int ADDR_W  = 16,
    parameter int DST_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ex_valid,
    output logic              o_ex_ready,
    input  logic [3:0]        i_ex_op,
    input  logic [DST_W-1:0]  i_ex_dst,
    input  logic [31:0]       i_ex_res,
    input  logic [31:0]       i_ex_stval,
    output logic [DST_W-1:0]  o_mem_dst,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [3:0]        o_dmem_be,
    output logic [31:0]       o_dmem_wdata,
    input  logic              i_dmem_ack,
    input  logic [31:0]       i_dmem_rdata,
    output logic              o_mem_valid,
    output logic [3:0]        o_mem_op,
    output logic [DST_W-1:0]  o_mem_dstq,
    output logic [31:0]       o_mem_res,
    output logic [31:0]       o_mem_memres,
    output logic              o_mem_exc,
    output logic              o_byp_valid,
    output logic [DST_W-1:0]  o_byp_dst,
    output logic [31:0]       o_byp_data
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_cnt;
    logic [3:0]       r_op;
    logic [DST_W-1:0] r_dst;
    logic [31:0]      r_res;

    logic w_accept, w_is_mem, w_is_store, w_is_word, w_is_half, w_misalign, w_start;
    logic w_ack, w_tmo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [15:0] w_lane;
    logic [31:0] w_ld_data;

    logic             w_o_vld, w_o_exc, w_o_load, w_byp_vld;
    logic [3:0]       w_o_op;
    logic [DST_W-1:0] w_o_dst;
    logic [31:0]      w_o_res, w_o_memres;

    assign o_ex_ready = (r_state == S_IDLE);
    assign o_mem_dst  = i_ex_valid ? i_ex_dst : '0;
    assign w_accept   = i_ex_valid && o_ex_ready;

    assign w_is_mem   = i_ex_op[3];
    assign w_is_store = (i_ex_op == 4'b1001) || (i_ex_op[3:1] == 3'b111);
    assign w_is_word  = (i_ex_op[3:1] == 3'b100);
    assign w_is_half  = (i_ex_op == 4'b1100) || (i_ex_op == 4'b1101) || (i_ex_op == 4'b1111);
    assign w_misalign = w_is_mem && ((w_is_half && i_ex_res[0]) || (w_is_word && (i_ex_res[1:0] != 2'b00)));
    assign w_start    = w_accept && w_is_mem && !w_misalign;

    assign w_ack = (r_state == S_WAIT) && i_dmem_ack;
    assign w_tmo = (r_state == S_WAIT) && !i_dmem_ack && (r_cnt == 8'(TIMEOUT - 1));

    always_comb begin
        w_be    = 4'b0001 << i_ex_res[1:0];
        w_wdata = {4{i_ex_stval[7:0]}};
        if (w_is_word) begin
            w_be    = 4'b1111;
            w_wdata = i_ex_stval;
        end else if (w_is_half) begin
            w_be    = i_ex_res[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_ex_stval[15:0]}};
        end
    end

    // Aligned accesses only, so shifting by the byte offset puts the wanted lane at bit 0.
    assign w_lane = 16'(i_dmem_rdata >> {r_res[1:0], 3'b000});

    always_comb begin
        case (r_op)
            4'b1000: w_ld_data = i_dmem_rdata;
            4'b1010: w_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
            4'b1011: w_ld_data = {24'd0, w_lane[7:0]};
            4'b1100: w_ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
            4'b1101: w_ld_data = {16'd0, w_lane[15:0]};
            default: w_ld_data = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_ack || w_tmo) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_o_vld    = 1'b0;
        w_o_exc    = 1'b0;
        w_o_op     = '0;
        w_o_dst    = '0;
        w_o_res    = '0;
        w_o_memres = '0;
        if (w_accept && (!w_is_mem || w_misalign)) begin
            w_o_vld = 1'b1;
            w_o_exc = w_misalign;
            w_o_op  = i_ex_op;
            w_o_dst = i_ex_dst;
            w_o_res = i_ex_res;
        end else if (w_ack || w_tmo) begin
            w_o_vld    = 1'b1;
            w_o_exc    = w_tmo;
            w_o_op     = r_op;
            w_o_dst    = r_dst;
            w_o_res    = r_res;
            w_o_memres = w_ack ? w_ld_data : '0;
        end
    end

    assign w_o_load  = w_o_op[3] && !((w_o_op == 4'b1001) || (w_o_op[3:1] == 3'b111));
    assign w_byp_vld = w_o_vld && !w_o_exc && (!w_o_op[3] || w_o_load);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt        <= '0;
            r_op         <= '0;
            r_dst        <= '0;
            r_res        <= '0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_be    <= '0;
            o_dmem_wdata <= '0;
            o_mem_valid  <= 1'b0;
            o_mem_op     <= '0;
            o_mem_dstq   <= '0;
            o_mem_res    <= '0;
            o_mem_memres <= '0;
            o_mem_exc    <= 1'b0;
            o_byp_valid  <= 1'b0;
            o_byp_dst    <= '0;
            o_byp_data   <= '0;
        end else begin
            if (w_start) begin
                r_op         <= i_ex_op;
                r_dst        <= i_ex_dst;
                r_res        <= i_ex_res;
                o_dmem_req   <= 1'b1;
                o_dmem_we    <= w_is_store;
                o_dmem_addr  <= i_ex_res[ADDR_W+1:2];
                o_dmem_be    <= w_be;
                o_dmem_wdata <= w_wdata;
            end else if (w_ack || w_tmo) begin
                o_dmem_req <= 1'b0;
                o_dmem_we  <= 1'b0;
            end
            r_cnt        <= (r_state == S_WAIT && !w_ack && !w_tmo) ? r_cnt + 8'd1 : '0;
            o_mem_valid  <= w_o_vld;
            o_mem_op     <= w_o_op;
            o_mem_dstq   <= w_o_dst;
            o_mem_res    <= w_o_res;
            o_mem_memres <= w_o_memres;
            o_mem_exc    <= w_o_exc;
            o_byp_valid  <= w_byp_vld;
            o_byp_dst    <= w_byp_vld ? w_o_dst : '0;
            o_byp_data   <= w_byp_vld ? (w_o_load ? w_o_memres : w_o_res) : '0;
        end
    end
endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: transaction-level predictor plus per-cycle output compare.
module tb_mem_stage_hs;
    localparam int ADDR_W = 16;
    localparam int DST_W  = 5;
    localparam int TMO    = 15;

    logic              clk = 1'b0;
    logic              i_reset, i_ex_valid, i_dmem_ack;
    logic [3:0]        i_ex_op;
    logic [DST_W-1:0]  i_ex_dst;
    logic [31:0]       i_ex_res, i_ex_stval, i_dmem_rdata;
    logic              o_ex_ready, o_dmem_req, o_dmem_we, o_mem_valid, o_mem_exc, o_byp_valid;
    logic [DST_W-1:0]  o_mem_dst, o_mem_dstq, o_byp_dst;
    logic [ADDR_W-1:0] o_dmem_addr;
    logic [3:0]        o_dmem_be, o_mem_op;
    logic [31:0]       o_dmem_wdata, o_mem_res, o_mem_memres, o_byp_data;

    always #5 clk = ~clk;

    mem_stage_hs #(.ADDR_W(ADDR_W), .DST_W(DST_W), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_ex_valid(i_ex_valid), .o_ex_ready(o_ex_ready),
        .i_ex_op(i_ex_op), .i_ex_dst(i_ex_dst), .i_ex_res(i_ex_res), .i_ex_stval(i_ex_stval),
        .o_mem_dst(o_mem_dst), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata), .o_mem_valid(o_mem_valid),
        .o_mem_op(o_mem_op), .o_mem_dstq(o_mem_dstq), .o_mem_res(o_mem_res),
        .o_mem_memres(o_mem_memres), .o_mem_exc(o_mem_exc), .o_byp_valid(o_byp_valid),
        .o_byp_dst(o_byp_dst), .o_byp_data(o_byp_data)
    );

    typedef struct {
        logic [3:0]       op;
        logic [DST_W-1:0] dst;
        logic [31:0]      res;
        logic [31:0]      memres;
        logic             exc;
        logic             byp_vld;
        logic [DST_W-1:0] byp_dst;
        logic [31:0]      byp_data;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;
    logic              last_we;
    logic [ADDR_W-1:0] last_addr;
    logic [3:0]        last_be;
    logic [31:0]       last_wdata;
    int                wait_lo;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int acc_size(input logic [3:0] op);
        if (op == 4'b1000 || op == 4'b1001) return 4;
        if (op == 4'b1100 || op == 4'b1101 || op == 4'b1111) return 2;
        return 1;
    endfunction

    function automatic bit is_load(input logic [3:0] op);
        return op inside {4'b1000, 4'b1010, 4'b1011, 4'b1100, 4'b1101};
    endfunction

    function automatic bit is_store(input logic [3:0] op);
        return op inside {4'b1001, 4'b1110, 4'b1111};
    endfunction

    function automatic exp_t predict(input logic [3:0] op, input logic [DST_W-1:0] dst,
                                     input logic [31:0] res, input logic [31:0] rdata, input bit tmo);
        exp_t e;
        longint v, span;
        int sz, off;
        e.op = op; e.dst = dst; e.res = res; e.memres = 0; e.exc = 0;
        e.byp_vld = 0; e.byp_dst = 0; e.byp_data = 0;
        if (!op[3]) begin
            e.byp_vld = 1; e.byp_dst = dst; e.byp_data = res;
            return e;
        end
        sz  = acc_size(op);
        off = int'(res[1:0]);
        e.exc = tmo || (off % sz != 0);
        if (is_load(op) && !e.exc) begin
            span = longint'(1) << (8 * sz);
            v = longint'(rdata >> (8 * off)) % span;
            if ((op == 4'b1010 || op == 4'b1100) && v >= span / 2) v = v - span;
            e.memres = v[31:0];
            e.byp_vld = 1; e.byp_dst = dst; e.byp_data = e.memres;
        end
        return e;
    endfunction

    function automatic logic [3:0] exp_be(input logic [3:0] op, input logic [31:0] res);
        int sz;
        sz = acc_size(op);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << int'(res[1:0]));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [3:0] op, input logic [31:0] stval);
        int sz;
        sz = acc_size(op);
        if (sz == 1) return {24'd0, stval[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'd0, stval[15:0]} * 32'h0001_0001;
        return stval;
    endfunction

    // delay = 0 means the memory never acknowledges.
    task automatic issue(input logic [3:0] op, input logic [DST_W-1:0] dst, input logic [31:0] res,
                         input logic [31:0] stval, input logic [31:0] rdata, input int delay);
        exp_t e;
        int lim;
        e = predict(op, dst, res, rdata, 1'b0);
        @(posedge clk); #1;
        i_ex_valid = 1'b1; i_ex_op = op; i_ex_dst = dst; i_ex_res = res; i_ex_stval = stval;
        #1 chk("mem_dst", 32'(o_mem_dst), 32'(dst));
        @(negedge clk);
        chk("ex_ready_idle", 32'(o_ex_ready), 1);
        if (!op[3] || e.exc) begin
            #1 q.push_back(e);
            @(posedge clk); #1;
            i_ex_valid = 1'b0;
            chk("no_req", 32'(o_dmem_req), 0);
            return;
        end
        @(posedge clk); #1;
        i_ex_valid = 1'b0; i_ex_op = 4'b0000;
        lim = (delay == 0) ? TMO : delay;
        wait_lo = 0;
        for (int k = 1; k <= lim; k++) begin
            @(negedge clk);
            if (!o_ex_ready) wait_lo++;
            chk("req_held", 32'(o_dmem_req), 1);
            chk("we", 32'(o_dmem_we), 32'(is_store(op)));
            chk("addr", 32'(o_dmem_addr), 32'(res[ADDR_W+1:2]));
            chk("be", 32'(o_dmem_be), 32'(exp_be(op, res)));
            if (is_store(op)) chk("wdata", o_dmem_wdata, exp_wdata(op, stval));
            last_we = o_dmem_we; last_addr = o_dmem_addr; last_be = o_dmem_be; last_wdata = o_dmem_wdata;
            if (k == lim) begin
                #1;
                if (delay != 0) begin
                    i_dmem_ack = 1'b1; i_dmem_rdata = rdata;
                end
                q.push_back(predict(op, dst, res, rdata, delay == 0));
            end
        end
        @(posedge clk); #1;
        i_dmem_ack = 1'b0; i_dmem_rdata = 32'h0;
        chk("req_drop", 32'(o_dmem_req), 0);
        chk("ready_back", 32'(o_ex_ready), 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("cmp_valid", 32'(o_mem_valid), 1);
            chk("cmp_op", 32'(o_mem_op), 32'(e.op));
            chk("cmp_dstq", 32'(o_mem_dstq), 32'(e.dst));
            chk("cmp_res", o_mem_res, e.res);
            chk("cmp_memres", o_mem_memres, e.memres);
            chk("cmp_exc", 32'(o_mem_exc), 32'(e.exc));
            chk("cmp_byp_valid", 32'(o_byp_valid), 32'(e.byp_vld));
            chk("cmp_byp_dst", 32'(o_byp_dst), 32'(e.byp_dst));
            chk("cmp_byp_data", o_byp_data, e.byp_data);
        end else begin
            chk("cmp_bubble_valid", 32'(o_mem_valid), 0);
            chk("cmp_bubble_byp", 32'(o_byp_valid), 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        i_reset = 1'b1; i_ex_valid = 1'b0; i_ex_op = 4'h0; i_ex_dst = '0;
        i_ex_res = 32'h0; i_ex_stval = 32'h0; i_dmem_ack = 1'b0; i_dmem_rdata = 32'h0;
        #22;
        chk("rst_req", 32'(o_dmem_req), 0);
        chk("rst_ready", 32'(o_ex_ready), 1);
        chk("rst_valid", 32'(o_mem_valid), 0);
        chk("rst_byp", 32'(o_byp_valid), 0);
        chk("rst_addr", 32'(o_dmem_addr), 0);
        chk("rst_be", 32'(o_dmem_be), 0);
        chk("rst_memdst", 32'(o_mem_dst), 0);
        i_reset = 1'b0;

        issue(4'b0010, 5'd3, 32'h1234, 32'h0, 32'h0, 0);
        chk("alu_valid", 32'(o_mem_valid), 1);
        chk("alu_res", o_mem_res, 32'h1234);
        chk("alu_byp_valid", 32'(o_byp_valid), 1);
        chk("alu_byp_data", o_byp_data, 32'h1234);
        chk("alu_byp_dst", 32'(o_byp_dst), 3);

        issue(4'b1110, 5'd4, 32'h6, 32'hAB, 32'h0, 3);
        chk("sb_addr", 32'(last_addr), 1);
        chk("sb_be", 32'(last_be), 32'b0100);
        chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
        chk("sb_we", 32'(last_we), 1);
        chk("sb_ready_low", 32'(wait_lo), 3);
        chk("sb_valid", 32'(o_mem_valid), 1);
        chk("sb_byp", 32'(o_byp_valid), 0);

        issue(4'b1010, 5'd5, 32'h7, 32'h0, 32'h80FF_FFFF, 1);
        chk("lb_memres", o_mem_memres, 32'hFFFF_FF80);
        chk("lb_byp", o_byp_data, 32'hFFFF_FF80);
        issue(4'b1011, 5'd6, 32'h7, 32'h0, 32'h80FF_FFFF, 2);
        chk("lbu_memres", o_mem_memres, 32'h0000_0080);
        issue(4'b1100, 5'd7, 32'h2, 32'h0, 32'h8001_5A5A, 1);
        chk("lh_memres", o_mem_memres, 32'hFFFF_8001);

        issue(4'b1000, 5'd8, 32'h5, 32'h0, 32'h0, 1);
        chk("mis_exc", 32'(o_mem_exc), 1);
        chk("mis_valid", 32'(o_mem_valid), 1);
        chk("mis_byp", 32'(o_byp_valid), 0);
        chk("mis_ready", 32'(o_ex_ready), 1);

        issue(4'b1000, 5'd9, 32'h100, 32'h0, 32'h0, 0);
        chk("tmo_exc", 32'(o_mem_exc), 1);
        chk("tmo_memres", o_mem_memres, 0);
        chk("tmo_req_cycles", 32'(wait_lo), 15);

        issue(4'b1000, 5'd10, 32'h104, 32'h0, 32'hDEAD_BEEF, 15);
        chk("ack15_exc", 32'(o_mem_exc), 0);
        chk("ack15_memres", o_mem_memres, 32'hDEAD_BEEF);
        chk("ack15_addr", 32'(last_addr), 32'h41);

        issue(4'b1111, 5'd11, 32'h2, 32'h1234_5678, 32'h0, 2);
        chk("sh_be", 32'(last_be), 32'b1100);
        chk("sh_wdata", last_wdata, 32'h5678_5678);
        issue(4'b1101, 5'd12, 32'h2, 32'h0, 32'hF00D_1234, 1);
        chk("lhu_memres", o_mem_memres, 32'h0000_F00D);
        issue(4'b1100, 5'd13, 32'h1, 32'h0, 32'h0, 1);
        chk("lh_mis_exc", 32'(o_mem_exc), 1);
        issue(4'b1001, 5'd14, 32'h10, 32'hCAFE_BABE, 32'h0, 1);
        chk("sw_be", 32'(last_be), 32'hF);
        chk("sw_wdata", last_wdata, 32'hCAFE_BABE);
        issue(4'b0101, 5'd15, 32'hFFFF_FFFF, 32'h0, 32'h0, 0);

        // Reset in the middle of a wait, then a stray ack afterwards.
        @(posedge clk); #1;
        i_ex_valid = 1'b1; i_ex_op = 4'b1000; i_ex_dst = 5'd7; i_ex_res = 32'h40;
        @(posedge clk); #1;
        i_ex_valid = 1'b0;
        @(negedge clk);
        chk("rw_req_before", 32'(o_dmem_req), 1);
        #2 i_reset = 1'b1;
        #1;
        chk("rw_req_now", 32'(o_dmem_req), 0);
        chk("rw_ready", 32'(o_ex_ready), 1);
        chk("rw_valid", 32'(o_mem_valid), 0);
        chk("rw_addr", 32'(o_dmem_addr), 0);
        @(negedge clk);
        i_reset = 1'b0;
        @(posedge clk); #1;
        i_dmem_ack = 1'b1; i_dmem_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        i_dmem_ack = 1'b0;
        chk("late_ack_valid", 32'(o_mem_valid), 0);
        chk("late_ack_ready", 32'(o_ex_ready), 1);
        chk("late_ack_req", 32'(o_dmem_req), 0);

        issue(4'b0001, 5'd2, 32'h55AA, 32'h0, 32'h0, 0);
        chk("post_rst_res", o_mem_res, 32'h55AA);
        repeat (3) @(posedge clk);
        #1 chk("queue_drained", 32'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Parametrised next-generation MEM pipeline stage. Accepts one EX-stage instruction per cycle over a ready/valid port and issues loads/stores to an external data memory with a request/acknowledge handshake of variable latency. Supports byte, halfword and word accesses with alignment checking and an access timeout. Produces the registered MEM/WB bus and a registered forwarding (bypass) path.

Parameters:
ADDR_W, 16, width of the word address driven to data memory (taken from res[ADDR_W+1:2])
DST_W, 5, destination register index width
TIMEOUT, 15, maximum cycles to wait for dmem_ack before aborting (1..255)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
ex_valid  in  1  EX instruction valid
ex_ready  out  1  stage can accept; high only in IDLE
ex_op  in  4  opcode; op[3]=0 ALU pass-through; 1000 lw, 1001 sw, 1010 lb, 1011 lbu, 1100 lh, 1101 lhu, 1110 sb, 1111 sh
ex_dst  in  DST_W  destination register
ex_res  in  32  ALU result / effective byte address
ex_stval  in  32  store data
mem_dst  out  DST_W  combinational: ex_dst when ex_valid, else 0 (hazard detection)
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  write request
dmem_addr  out  ADDR_W  word address
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated write data
dmem_ack  in  1  memory completion, one-cycle pulse
dmem_rdata  in  32  read word, valid with ack
mem_valid  out  1  registered output valid
mem_op  out  4  registered opcode
mem_dstq  out  DST_W  registered destination
mem_res  out  32  registered ALU result / address
mem_memres  out  32  registered extended load data (0 for non-loads)
mem_exc  out  1  misalignment or timeout
byp_valid  out  1  bypass valid
byp_dst  out  DST_W  bypass destination
byp_data  out  32  bypass value

Behaviour:
- Reset (async): state IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata = 0; all mem_*/byp_* registered outputs = 0; timeout counter = 0.
- States: IDLE, WAIT. ex_ready = (state==IDLE). Transfer occurs when ex_valid && ex_ready.
- IDLE, ALU op accepted: next edge loads output register (mem_valid=1, mem_memres=0). Latency 1.
- IDLE, memory op accepted, aligned: latch op/dst/res/stval; next edge drive dmem_req=1, dmem_we=store, dmem_addr, dmem_be, dmem_wdata; go WAIT; mem_valid=0 that edge.
- Alignment: halfword requires res[0]=0, word res[1:0]=0. Misaligned op: no memory access; output register loads next edge with mem_valid=1, mem_exc=1, mem_memres=0; stays IDLE.
- Lanes: sb be=1<<res[1:0], wdata={4{stval[7:0]}}; sh be=res[1]?1100:0011, wdata={2{stval[15:0]}}; sw be=1111, wdata=stval; loads be per same rule, dmem_we=0.
- Load extract: selected byte/halfword lane of dmem_rdata; lb/lh sign-extend, lbu/lhu zero-extend, lw whole word.
- WAIT: counter increments each cycle without ack. On dmem_ack: drop dmem_req/dmem_we same edge, load output register (mem_valid=1, mem_memres=extracted data), return IDLE, clear counter. If counter reaches TIMEOUT without ack: drop req, output mem_valid=1, mem_exc=1, mem_memres=0, return IDLE. Ack in the same cycle as timeout: ack wins.
- dmem_* signals stable for entire WAIT; ack outside WAIT ignored.
- Cycles with no accepted transfer and no completion: mem_valid=0 next edge (bubble).
- Bypass (registered, same edge as output): byp_valid=1 when output valid, mem_exc=0, op is ALU or load; byp_data = load ? extracted data : res; byp_dst = dst. Otherwise all byp_* = 0.
- Reset asserted mid-WAIT: dmem_req falls immediately; in-flight access discarded.

Test Plan:
- ALU op 0010, res=0x1234, dst=3 -> one cycle later mem_valid=1, mem_res=0x1234, byp_valid=1, byp_data=0x1234, byp_dst=3.
- sb res=0x00000006, stval=0xAB -> dmem_addr=1, be=0100, wdata=0xABABABAB; ack after 3 cycles -> ex_ready low 3 cycles, mem_valid=1, byp_valid=0.
- lb then lbu at res=0x7, rdata=0x80FFFFFF -> mem_memres 0xFFFFFF80 then 0x00000080; lh res=0x2 rdata=0x8001xxxx -> 0xFFFF8001.
- lw res=0x5 -> no dmem_req, mem_exc=1, mem_valid=1, byp_valid=0, ex_ready stays high.
- lw with dmem_ack never asserted, TIMEOUT=15 -> dmem_req high 15 cycles, then mem_exc=1, state IDLE; ack on cycle 15 instead -> normal completion.
- reset pulsed during WAIT -> dmem_req 0 immediately, all outputs 0, ex_ready=1 after release; late ack ignored.
